// File: rtl/tile_fifo_ctrl.sv
// tile_fifo_ctrl: sequencing controller for one simple dual-port tile RAM
// (1 write port, 1 registered read port with 1-cycle latency).
// Owns the write/read pointers and occupancy, prefetches through the RAM
// latency into a 2-entry output buffer and presents a valid/ready stream.
// Optional feature: define TILE_FIFO_CTRL_DROP_ON_FULL_EN to discard words
// arriving while full (counted in drop_cnt) instead of backpressuring.
module tile_fifo_ctrl #(
    parameter int DATA_WIDTH = 40,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           drop_cnt
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wptr_reg;
    logic [ADDR_WIDTH-1:0] rptr_reg;
    logic [ADDR_WIDTH:0]   ram_cnt_reg;
    logic [ADDR_WIDTH:0]   ram_cnt_next;
    logic                  inflight_reg;
    logic [1:0]            obuf_cnt_reg;
    logic [DATA_WIDTH-1:0] obuf_head_reg;
    logic [DATA_WIDTH-1:0] obuf_tail_reg;

    logic accept;
    logic issue;
    logic deq;

    // ram_cnt holds committed words only, so a word written this cycle is
    // not readable until the next one; equal pointers then imply either an
    // empty RAM (no issue) or a full RAM (no write).
    assign full      = (ram_cnt_reg == DEPTH_CNT);
    assign out_valid = (obuf_cnt_reg != 2'd0);
    assign out_data  = obuf_head_reg;
    assign deq       = out_valid & out_ready;

`ifdef TILE_FIFO_CTRL_DROP_ON_FULL_EN
    logic drop;
    logic [15:0] drop_cnt_reg;

    assign in_ready = !flush;
    assign accept   = in_valid & !flush & !full;
    assign drop     = in_valid & !flush & full;
    assign drop_cnt = drop_cnt_reg;

    // Saturating count of words discarded while full; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= 16'd0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end
`else
    assign in_ready = !full & !flush;
    assign accept   = in_valid & in_ready;
    assign drop_cnt = 16'd0;
`endif

    // Issue only while the buffer plus the word in flight, less this cycle's
    // dequeue, still leaves a free slot for the returning read.
    assign issue = !flush && (ram_cnt_reg != '0) &&
                   (({1'b0, obuf_cnt_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, deq}));

    assign ram_we    = accept;
    assign ram_waddr = wptr_reg;
    assign ram_wdata = in_data;
    assign ram_raddr = rptr_reg;

    assign level = {1'b0, ram_cnt_reg}
                 + {{(ADDR_WIDTH+1){1'b0}}, inflight_reg}
                 + {{ADDR_WIDTH{1'b0}}, obuf_cnt_reg};
    assign empty = (level == '0);

    // Committed-word count: accept and issue in one cycle cancel out.
    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        case ({accept, issue})
            2'b10:   ram_cnt_next = ram_cnt_reg + CNT_ONE;
            2'b01:   ram_cnt_next = ram_cnt_reg - CNT_ONE;
            default: ram_cnt_next = ram_cnt_reg;
        endcase
    end

    // Pointers, RAM occupancy and the in-flight read marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else if (flush) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else begin
            if (accept) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (issue) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            ram_cnt_reg  <= ram_cnt_next;
            inflight_reg <= issue;
        end
    end

    // Two-entry output buffer: captures ram_q when a read is in flight,
    // shifts the tail into the head on dequeue. A ram_q landing during
    // flush is dropped because the count is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_cnt_reg  <= 2'd0;
            obuf_head_reg <= '0;
            obuf_tail_reg <= '0;
        end else if (flush) begin
            obuf_cnt_reg <= 2'd0;
        end else begin
            case ({inflight_reg, deq})
                2'b10: begin
                    if (obuf_cnt_reg == 2'd0) begin
                        obuf_head_reg <= ram_q;
                    end else begin
                        obuf_tail_reg <= ram_q;
                    end
                    obuf_cnt_reg <= obuf_cnt_reg + 2'd1;
                end
                2'b01: begin
                    obuf_head_reg <= obuf_tail_reg;
                    obuf_cnt_reg  <= obuf_cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (obuf_cnt_reg == 2'd1) begin
                        obuf_head_reg <= ram_q;
                    end else begin
                        obuf_head_reg <= obuf_tail_reg;
                        obuf_tail_reg <= ram_q;
                    end
                end
                default: begin
                    obuf_cnt_reg <= obuf_cnt_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_fifo_ctrl.sv
// Bench for tile_fifo_ctrl with a 16-word behavioural tile RAM
// (registered read, old data on same-address read/write).
module tb_tile_fifo_ctrl;

    localparam int DW = 40;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_q;
    logic [AW+1:0] level;
    logic          full;
    logic          empty;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    tile_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_q(ram_q),
        .level(level), .full(full), .empty(empty), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_q <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard, hazard and throughput monitor (samples on the falling edge).
    logic [DW-1:0] sb_q [$];
    int cyc = 0;
    int phase_pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int hazard_cnt = 0;
    logic          cand_prev = 1'b0;
    logic [AW-1:0] raddr_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cand_prev && (ram_raddr != raddr_prev)) hazard_cnt++;
            cand_prev  = ram_we && (ram_waddr == ram_raddr) && !flush;
            raddr_prev = ram_raddr;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {24'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("sb_word", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                phase_pops++;
            end
`ifdef TILE_FIFO_CTRL_DROP_ON_FULL_EN
            if (in_valid && in_ready && !full) sb_q.push_back(in_data);
`else
            if (in_valid && in_ready) sb_q.push_back(in_data);
`endif
            if (flush) sb_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic phase_reset();
        phase_pops = 0;
        first_pop  = -1;
        last_pop   = -1;
    endtask

    // Present words base..base+n-1, holding each until accepted.
    task automatic send_words(input int n, input logic [DW-1:0] base, input int budget);
        int sent = 0;
        int t = 0;
        while (sent < n && t < budget) begin
            in_valid = 1'b1;
            in_data  = base + DW'(sent);
            @(negedge clk);
            if (in_ready) sent++;
            step();
            t++;
        end
        in_valid = 1'b0;
        check("send_done", 64'(sent), 64'(n));
    endtask

    task automatic wait_empty(input string name, input int budget);
        int t = 0;
        while (!empty && t < budget) begin
            step();
            t++;
        end
        @(negedge clk);
        check(name, {63'd0, empty}, 64'd1);
        step();
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ov;
        logic [DW-1:0] od;
        int            lvl;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy,
                                logic ov, logic [DW-1:0] od, int lvl);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov; v.od = od; v.lvl = lvl;
        return v;
    endfunction

    vec_t vecs [0:18];

    initial begin
        int acc;
        int irdy_low;
        int ov_seen;
        int t;

        vecs[0]  = mk(1, 40'h01, 1, 0, 40'h00, 0);
        vecs[1]  = mk(0, 40'h00, 1, 0, 40'h00, 1);
        vecs[2]  = mk(0, 40'h00, 1, 0, 40'h00, 1);
        vecs[3]  = mk(0, 40'h00, 1, 1, 40'h01, 1);
        vecs[4]  = mk(0, 40'h00, 1, 0, 40'h00, 0);
        vecs[5]  = mk(1, 40'h22, 1, 0, 40'h00, 0);
        vecs[6]  = mk(1, 40'h33, 1, 0, 40'h00, 1);
        vecs[7]  = mk(0, 40'h00, 1, 0, 40'h00, 2);
        vecs[8]  = mk(0, 40'h00, 1, 1, 40'h22, 2);
        vecs[9]  = mk(0, 40'h00, 1, 1, 40'h33, 1);
        vecs[10] = mk(0, 40'h00, 1, 0, 40'h00, 0);
        vecs[11] = mk(1, 40'h44, 0, 0, 40'h00, 0);
        vecs[12] = mk(1, 40'h55, 0, 0, 40'h00, 1);
        vecs[13] = mk(0, 40'h00, 0, 0, 40'h00, 2);
        vecs[14] = mk(0, 40'h00, 0, 1, 40'h44, 2);
        vecs[15] = mk(0, 40'h00, 0, 1, 40'h44, 2);
        vecs[16] = mk(0, 40'h00, 1, 1, 40'h44, 2);
        vecs[17] = mk(0, 40'h00, 1, 1, 40'h55, 1);
        vecs[18] = mk(0, 40'h00, 1, 0, 40'h00, 0);

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {24'd0, out_data}, 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_waddr", 64'(ram_waddr), 64'd0);
        check("rst_raddr", 64'(ram_raddr), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // Table: latency, back-to-back, backpressure
        for (int i = 0; i < 19; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            $display("vec %0d: iv=%0d d=%0h ordy=%0d -> ov=%0d od=%0h lvl=%0d",
                     i, in_valid, in_data, out_ready, out_valid, out_data, level);
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
            if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].od});
            check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
            check($sformatf("vec%0d_empty", i), {63'd0, empty}, (vecs[i].lvl == 0) ? 64'd1 : 64'd0);
            check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            check($sformatf("vec%0d_ram_we", i), {63'd0, ram_we}, {63'd0, vecs[i].iv});
            step();
        end
        in_valid = 1'b0;

        // Stream 1000 words at full rate
        out_ready = 1'b1;
        phase_reset();
        send_words(1000, 40'h10_0000, 1200);
        wait_empty("stream_drain", 50);
        $display("stream: pops=%0d first=%0d last=%0d", phase_pops, first_pop, last_pop);
        check("stream_pops", 64'(phase_pops), 64'd1000);
        check("stream_no_gaps", 64'(last_pop - first_pop), 64'd999);

        // Fill with sink stalled
        out_ready = 1'b0;
        acc = 0;
        irdy_low = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
`ifdef TILE_FIFO_CTRL_DROP_ON_FULL_EN
            in_data = 40'h100 + 40'(i);
`else
            in_data = 40'h100 + 40'(acc);
`endif
            @(negedge clk);
            if (ram_we) acc++;
            if (!in_ready) irdy_low++;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        $display("fill: accepted=%0d level=%0d full=%0d drop_cnt=%0d", acc, level, full, drop_cnt);
        check("fill_accepted", 64'(acc), 64'd18);
        check("fill_full", {63'd0, full}, 64'd1);
        check("fill_level", 64'(level), 64'd18);
`ifdef TILE_FIFO_CTRL_DROP_ON_FULL_EN
        check("fill_drop_cnt", 64'(drop_cnt), 64'd2);
        check("fill_in_ready_low_cycles", 64'(irdy_low), 64'd0);
        check("fill_in_ready", {63'd0, in_ready}, 64'd1);
`else
        check("fill_drop_cnt", 64'(drop_cnt), 64'd0);
        check("fill_in_ready_low_cycles", 64'(irdy_low), 64'd2);
        check("fill_in_ready", {63'd0, in_ready}, 64'd0);
`endif
        step();

        // Release, then refill across the pointer wrap while draining
        phase_reset();
        out_ready = 1'b1;
        step();
        step();
        send_words(40, 40'h2000, 200);
        wait_empty("wrap_drain", 200);
        $display("wrap: pops=%0d hazards=%0d", phase_pops, hazard_cnt);
        check("wrap_pops", 64'(phase_pops), 64'd58);
        check("rdw_hazards", 64'(hazard_cnt), 64'd0);

        // Flush with a read in flight and a word presented
        in_valid = 1'b1;
        in_data  = 40'hAA;
        step();
        in_valid = 1'b0;
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 40'hBAD;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        check("flush_ram_we", {63'd0, ram_we}, 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        $display("flush: level=%0d empty=%0d ov=%0d", level, empty, out_valid);
        check("flush_level", 64'(level), 64'd0);
        check("flush_empty", {63'd0, empty}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        ov_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("flush_no_ghost", 64'(ov_seen), 64'd0);
        step();
        in_valid = 1'b1;
        in_data  = 40'h55;
        step();
        in_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            step();
            @(negedge clk);
            t++;
        end
        check("post_flush_out_valid", {63'd0, out_valid}, 64'd1);
        check("post_flush_out_data", {24'd0, out_data}, 64'h55);
        step();
        @(negedge clk);
        check("post_flush_empty", {63'd0, empty}, 64'd1);
`ifdef TILE_FIFO_CTRL_DROP_ON_FULL_EN
        check("drop_cnt_kept", 64'(drop_cnt), 64'd2);
`else
        check("drop_cnt_zero", 64'(drop_cnt), 64'd0);
`endif
        check("sb_leftover", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
